pwm_bank: RTL and testbench
===========================

Name: pwm_bank

Overview:
- Parametrised successor to the two-channel PWM register block: NUM_CH independent PWM outputs, CNT_W-bit shared period counter, memory-mapped register bus (cs/rd/wr/addr/d_in/d_out).
- Duty and period writes land in shadow registers. They are copied to the active registers only at a period boundary, so each PWM period is glitch-free.
- Sits under the bus sequencer/host; drives servo/motor PWM pins and a per-period `done` strobe.

Parameters:
- NUM_CH, 8, number of PWM channels (1..16)
- CNT_W, 16, counter / period / duty width (≤ DATA_W)
- DATA_W, 32, bus data width
- ADDR_W, 8, bus address width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cs  in  1  chip select
- rd  in  1  read strobe (qualified by cs)
- wr  in  1  write strobe (qualified by cs)
- addr  in  ADDR_W  register address
- d_in  in  DATA_W  write data
- d_out  out  DATA_W  read data, registered
- pwm  out  NUM_CH  PWM outputs, registered
- done  out  1  one-cycle pulse at each period wrap

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-low (rst_n).
- Register map (word addresses):
  - 0x00 CTRL: bit0 EN (R/W); bit1 UPD (write-1 sets pending, reads as pending)
  - 0x01 PERIOD shadow [CNT_W-1:0]
  - 0x02 STATUS (RO): bit0 pending; bit1 EN; [31:16] counter value
  - 0x10+i DUTY[i] shadow, i < NUM_CH
  - Unmapped reads return 0; unmapped writes are ignored.
- Reset: all of the following clear to 0 — counter, shadows, actives, EN, pending, pwm, done, d_out.
- Bus write: takes effect on the clk edge where cs&wr=1.
- Bus read: cs&rd registers d_out on that edge (1-cycle latency). d_out holds its value when no read occurs.
  - cs&rd&wr together: the write happens; d_out returns the pre-write value.
- Counter, EN=1:
  - Counts 0..period_act, then wraps to 0.
  - Wrap cycle = the cycle where cnt==period_act. On that edge: done=1 for one cycle; if pending=1, copy all shadows to actives and clear pending.
  - A UPD write landing on the wrap edge sets pending for the following wrap.
  - period_act=0: wrap every cycle; done stays high continuously.
- Counter, EN=0:
  - Counter held at 0; pwm=0; done=0.
  - Actives track shadows every cycle; pending is cleared.
  - On the EN 0→1 edge, the first period starts at cnt=0 with the latest shadow values.
- pwm[i] is registered: pwm[i] <= EN & (cnt_next < duty_act[i]), where cnt_next is the counter value after the edge.
  - duty=0 → constant low.
  - duty > period → constant high.
  - High time is duty cycles per period of (period+1) cycles.
- EN cleared mid-period: on the next edge the counter is 0 and all outputs are low; no done pulse is generated.
- rst_n asserted mid-period: immediate asynchronous clear of all state; no partial update.
- Widths: shadows and actives are CNT_W bits; write data is truncated to CNT_W; reads are zero-extended to DATA_W.

Optional Feature:
- Macro: PWM_BANK_POLARITY_EN
- Defined:
  - Adds register 0x03 POL [NUM_CH-1:0], R/W, reset 0.
  - POL is shadowed and updated at the wrap like DUTY.
  - pwm[i] is XORed with pol_act[i] while EN=1. While EN=0, pwm[i] = pol_act[i] (idle at the inactive level).
- Undefined: address 0x03 is unmapped; outputs are active-high only.

Decomposition:
- Package pwm_bank_pkg:
  - Address constants: ADDR_CTRL, ADDR_PERIOD, ADDR_STATUS, ADDR_POL, ADDR_DUTY_BASE
  - CTRL bit indices: CTRL_EN, CTRL_UPD
  - Typedef for the CNT_W counter word
- Sub-module pwm_bank_ch: one per channel via generate.
  - Holds duty shadow, duty active and the comparator.
  - Inputs: cnt_next, EN, load strobe, write strobe.

Test Plan:
- Reset: hold rst_n=0, toggle clk → pwm=0, done=0, d_out=0; all register reads return 0 after release.
- Basic PWM: PERIOD=9, DUTY0=3, UPD, EN=1 → pwm[0] high 3 / low 7 cycles, period 10 cycles, done every 10th cycle; other channels stay low.
- Shadow timing: running with DUTY0=3, write DUTY0=7 and UPD mid-period → the current period keeps 3 high cycles; from the next wrap, 7; STATUS.pending reads 1 until the wrap, then 0.
- Boundaries: DUTY1=0 → pwm[1] constant low. DUTY2=12 with PERIOD=9 → pwm[2] constant high. PERIOD=0 → done constantly high.
- Bus corner cases:
  - Read at 0x55 → d_out=0.
  - Simultaneous rd/wr to PERIOD (old 9, new 4) → d_out=9, the new shadow is 4.
  - EN cleared mid-period → next cycle pwm all 0, counter 0, no done pulse.
- (PWM_BANK_POLARITY_EN) POL=0x1, DUTY0=3, PERIOD=9 → pwm[0] low 3 / high 7; with EN=0, pwm[0]=1.

Source files
------------

// File: rtl/pwm_bank_pkg.sv
// Shared register map, control-bit indices and counter word type for the pwm_bank block.
// Optional polarity register is enabled by defining PWM_BANK_POLARITY_EN.
package pwm_bank_pkg;

  localparam int unsigned ADDR_CTRL      = 32'h00;
  localparam int unsigned ADDR_PERIOD    = 32'h01;
  localparam int unsigned ADDR_STATUS    = 32'h02;
  localparam int unsigned ADDR_POL       = 32'h03;
  localparam int unsigned ADDR_DUTY_BASE = 32'h10;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_UPD = 1;

  // STATUS layout: pending/EN in the low bits, counter from bit 16 upward
  localparam int unsigned STATUS_CNT_LSB = 16;

  localparam int unsigned DEF_CNT_W = 16;
  typedef logic [DEF_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/pwm_bank_ch.sv
// One PWM channel: duty shadow/active pair and the registered comparator output.
module pwm_bank_ch #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] i_cnt_next,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_we,
  input  logic [CNT_W-1:0] i_wdata,
  input  logic             i_pol,
  output logic [CNT_W-1:0] o_duty_sh,
  output logic             o_pwm
);

  logic [CNT_W-1:0] r_duty_sh;
  logic [CNT_W-1:0] r_duty_act;
  logic             r_pwm;
  logic [CNT_W-1:0] w_duty_sh_d;
  logic [CNT_W-1:0] w_duty_act_d;
  logic             w_pwm_d;

  always_comb begin
    w_duty_sh_d  = i_we ? i_wdata : r_duty_sh;
    w_duty_act_d = i_load ? w_duty_sh_d : r_duty_act;
    // Compare against the post-edge active so a wrap-time update applies from cnt=0
    w_pwm_d      = i_en ? ((i_cnt_next < w_duty_act_d) ^ i_pol) : i_pol;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_sh  <= '0;
      r_duty_act <= '0;
      r_pwm      <= 1'b0;
    end else begin
      r_duty_sh  <= w_duty_sh_d;
      r_duty_act <= w_duty_act_d;
      r_pwm      <= w_pwm_d;
    end
  end

  assign o_duty_sh = r_duty_sh;
  assign o_pwm     = r_pwm;

endmodule

// File: rtl/pwm_bank.sv
// NUM_CH-channel PWM bank with shadowed period/duty registers applied at period wrap.
// Define PWM_BANK_POLARITY_EN to add the shadowed POL register at address 0x03.
module pwm_bank #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic [NUM_CH-1:0] pwm,
  output logic              done
);

  import pwm_bank_pkg::*;

  logic              r_en;
  logic              r_pending;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_period_sh;
  logic [CNT_W-1:0]  r_period_act;
  logic              r_done;
  logic [DATA_W-1:0] r_d_out;

  logic              w_wr;
  logic              w_rd;
  logic              w_wr_ctrl;
  logic              w_wr_period;
  logic              w_wrap;
  logic              w_load;
  logic              w_en_d;
  logic              w_pending_d;
  logic [CNT_W-1:0]  w_cnt_d;
  logic [CNT_W-1:0]  w_period_sh_d;
  logic [CNT_W-1:0]  w_period_act_d;
  logic              w_done_d;
  logic [DATA_W-1:0] w_rdata;
  logic [NUM_CH-1:0] w_duty_we;
  logic [NUM_CH-1:0] w_pol_act_d;
  logic [CNT_W-1:0]  w_duty_sh [NUM_CH];
  logic [STATUS_CNT_LSB+CNT_W-1:0] w_status;
  logic              w_unused_din;

  assign w_wr         = cs & wr;
  assign w_rd         = cs & rd;
  assign w_wr_ctrl    = w_wr && (addr == ADDR_W'(ADDR_CTRL));
  assign w_wr_period  = w_wr && (addr == ADDR_W'(ADDR_PERIOD));
  assign w_unused_din = ^d_in;

  always_comb begin
    w_wrap = r_en && (r_cnt == r_period_act);
    // Actives follow shadows continuously while disabled, otherwise only at a pending wrap
    w_load = !r_en || (w_wrap && r_pending);

    w_en_d = r_en;
    if (w_wr_ctrl) w_en_d = d_in[CTRL_EN];

    w_pending_d = r_pending;
    if (w_wrap && r_pending) w_pending_d = 1'b0;
    if (w_wr_ctrl && d_in[CTRL_UPD]) w_pending_d = 1'b1;
    if (!r_en || !w_en_d) w_pending_d = 1'b0;

    w_period_sh_d  = w_wr_period ? d_in[CNT_W-1:0] : r_period_sh;
    w_period_act_d = w_load ? w_period_sh_d : r_period_act;

    if (!r_en || !w_en_d || w_wrap) w_cnt_d = '0;
    else w_cnt_d = r_cnt + 1'b1;

    w_done_d = w_wrap && w_en_d;

    w_duty_we = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      w_duty_we[i] = w_wr && (addr == ADDR_W'(ADDR_DUTY_BASE + i));
    end
  end

`ifdef PWM_BANK_POLARITY_EN
  logic [NUM_CH-1:0] r_pol_sh;
  logic [NUM_CH-1:0] r_pol_act;
  logic [NUM_CH-1:0] w_pol_sh_d;

  always_comb begin
    w_pol_sh_d = r_pol_sh;
    if (w_wr && (addr == ADDR_W'(ADDR_POL))) w_pol_sh_d = d_in[NUM_CH-1:0];
    w_pol_act_d = w_load ? w_pol_sh_d : r_pol_act;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pol_sh  <= '0;
      r_pol_act <= '0;
    end else begin
      r_pol_sh  <= w_pol_sh_d;
      r_pol_act <= w_pol_act_d;
    end
  end
`else
  assign w_pol_act_d = '0;
`endif

  assign w_status = {r_cnt, (STATUS_CNT_LSB - 2)'(0), r_en, r_pending};

  // Read mux sees pre-edge state, so a simultaneous read/write returns the old value
  always_comb begin
    w_rdata = '0;
    if (addr == ADDR_W'(ADDR_CTRL)) begin
      w_rdata[CTRL_EN]  = r_en;
      w_rdata[CTRL_UPD] = r_pending;
    end else if (addr == ADDR_W'(ADDR_PERIOD)) begin
      w_rdata = DATA_W'(r_period_sh);
    end else if (addr == ADDR_W'(ADDR_STATUS)) begin
      w_rdata = DATA_W'(w_status);
    end
`ifdef PWM_BANK_POLARITY_EN
    if (addr == ADDR_W'(ADDR_POL)) w_rdata = DATA_W'(r_pol_sh);
`endif
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (addr == ADDR_W'(ADDR_DUTY_BASE + i)) w_rdata = DATA_W'(w_duty_sh[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en         <= 1'b0;
      r_pending    <= 1'b0;
      r_cnt        <= '0;
      r_period_sh  <= '0;
      r_period_act <= '0;
      r_done       <= 1'b0;
      r_d_out      <= '0;
    end else begin
      r_en         <= w_en_d;
      r_pending    <= w_pending_d;
      r_cnt        <= w_cnt_d;
      r_period_sh  <= w_period_sh_d;
      r_period_act <= w_period_act_d;
      r_done       <= w_done_d;
      if (w_rd) r_d_out <= w_rdata;
    end
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    pwm_bank_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_cnt_next (w_cnt_d),
      .i_en       (w_en_d),
      .i_load     (w_load),
      .i_we       (w_duty_we[g]),
      .i_wdata    (d_in[CNT_W-1:0]),
      .i_pol      (w_pol_act_d[g]),
      .o_duty_sh  (w_duty_sh[g]),
      .o_pwm      (pwm[g])
    );
  end

  assign d_out = r_d_out;
  assign done  = r_done;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: register table plus hand-written PWM timing sequences.
module tb_pwm_bank;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 8;

  logic              clk;
  logic              rst_n;
  logic              cs;
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] d_in;
  logic [DATA_W-1:0] d_out;
  logic [NUM_CH-1:0] pwm;
  logic              done;

  int n_tests;
  int n_fail;

  typedef struct {
    bit          do_wr;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  pwm_bank #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cs    (cs),
    .rd    (rd),
    .wr    (wr),
    .addr  (addr),
    .d_in  (d_in),
    .d_out (d_out),
    .pwm   (pwm),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    tick();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] v);
    cs = 1'b1; rd = 1'b1; addr = a;
    tick();
    cs = 1'b0; rd = 1'b0;
    v = d_out;
  endtask

  task automatic bus_rw(input logic [7:0] a, input logic [31:0] d, output logic [31:0] v);
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = a; d_in = d;
    tick();
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    v = d_out;
  endtask

  initial begin
    logic [31:0] rv;
    logic [7:0]  exp_pwm;
    bit          bad;

    n_tests = 0;
    n_fail  = 0;
    cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
    rst_n = 1'b0;

    vecs.push_back('{1'b0, 8'h00, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 8'h01, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 8'h02, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 8'h10, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 8'h17, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 8'h55, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 8'h01, 32'hABCD_0009, 32'h0000_0009});
    vecs.push_back('{1'b1, 8'h10, 32'h0001_0003, 32'h0000_0003});
    vecs.push_back('{1'b1, 8'h11, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 8'h12, 32'd12, 32'd12});
    vecs.push_back('{1'b1, 8'h55, 32'hFFFF, 32'h0});
    vecs.push_back('{1'b1, 8'h18, 32'd5, 32'h0});
    vecs.push_back('{1'b1, 8'h02, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b1, 8'h00, 32'h2, 32'h0});
`ifndef PWM_BANK_POLARITY_EN
    vecs.push_back('{1'b1, 8'h03, 32'hFF, 32'h0});
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_pwm", 32'(pwm), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_dout", d_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Register table, EN=0 throughout
    foreach (vecs[i]) begin
      if (vecs[i].do_wr) bus_write(vecs[i].a, vecs[i].wd);
      bus_read(vecs[i].a, rv);
      check($sformatf("reg_vec%0d_addr%02h", i, vecs[i].a), rv, vecs[i].exp);
    end

    // Basic PWM: PERIOD=9, DUTY0=3, DUTY1=0, DUTY2=12
    bus_write(8'h00, 32'h1);
    for (int k = 0; k < 30; k++) begin
      if (k > 0) tick();
      exp_pwm = ((k % 10) < 3) ? 8'h05 : 8'h04;
      check($sformatf("basic_pwm_k%0d", k), 32'(pwm), 32'(exp_pwm));
      check($sformatf("basic_done_k%0d", k), 32'(done), (k > 0 && (k % 10) == 0) ? 32'h1 : 32'h0);
    end

    // Shadow timing: counter is at 9 here
    bus_write(8'h10, 32'd7);
    check("shadow_wrap_done", 32'(done), 32'h1);
    check("shadow_c0_pwm", 32'(pwm), 32'h05);
    bus_write(8'h00, 32'h3);
    check("shadow_c1_pwm", 32'(pwm), 32'h05);
    bus_read(8'h02, rv);
    check("status_pending", rv, 32'h0001_0003);
    check("shadow_c2_pwm", 32'(pwm), 32'h05);
    for (int c = 3; c < 10; c++) begin
      tick();
      check($sformatf("shadow_old_c%0d", c), {23'h0, done, pwm}, 32'h004);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      exp_pwm = (c < 7) ? 8'h05 : 8'h04;
      check($sformatf("shadow_new_c%0d", c), {23'h0, done, pwm},
            {23'h0, (c == 0), exp_pwm});
    end
    bus_read(8'h02, rv);
    check("status_after_wrap", rv, 32'h0009_0002);

    // Simultaneous read/write of PERIOD
    bus_rw(8'h01, 32'd4, rv);
    check("rw_old_value", rv, 32'd9);
    bus_read(8'h01, rv);
    check("rw_new_shadow", rv, 32'd4);
    check("pre_disable_pwm", 32'(pwm), 32'h05);

    // EN cleared mid-period
    bus_write(8'h00, 32'h0);
    check("disable_pwm", 32'(pwm), 32'h0);
    check("disable_done", 32'(done), 32'h0);
    bus_read(8'h02, rv);
    check("disable_status", rv, 32'h0);
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done !== 1'b0 || pwm !== '0) bad = 1'b1;
    end
    check("disable_quiet", 32'(bad), 32'h0);

    // PERIOD=0: done high every cycle after the first
    bus_write(8'h01, 32'd0);
    bus_write(8'h00, 32'h1);
    check("p0_first_done", 32'(done), 32'h0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("p0_c%0d", c), {23'h0, done, pwm}, 32'h105);
    end

    // Asynchronous reset mid-run
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_pwm", 32'(pwm), 32'h0);
    check("async_rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus_read(8'h00, rv);
    check("post_rst_ctrl", rv, 32'h0);
    bus_read(8'h10, rv);
    check("post_rst_duty0", rv, 32'h0);

`ifdef PWM_BANK_POLARITY_EN
    bus_write(8'h01, 32'd9);
    bus_write(8'h10, 32'd3);
    bus_write(8'h03, 32'h1);
    tick();
    check("pol_idle", 32'(pwm), 32'h01);
    bus_read(8'h03, rv);
    check("pol_read", rv, 32'h1);
    bus_write(8'h00, 32'h1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      check($sformatf("pol_k%0d", k), 32'(pwm), (k < 3) ? 32'h0 : 32'h1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
